// File: rtl/xor_arb_ctrl_if.sv
// xor_arb_ctrl_if: request/operand/result bundle between clients and xor_arb_ctrl
// res_parity exists only when XOR_ARB_PARITY_EN is defined.
interface xor_arb_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_flat;
  logic [NREQ*WIDTH-1:0] b_flat;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
`ifdef XOR_ARB_PARITY_EN
  logic                  res_parity;
  modport master (output req, a_flat, b_flat, res_ready, input gnt, busy, res_valid, res_data, res_id, res_parity);
  modport slave  (input req, a_flat, b_flat, res_ready, output gnt, busy, res_valid, res_data, res_id, res_parity);
`else
  modport master (output req, a_flat, b_flat, res_ready, input gnt, busy, res_valid, res_data, res_id);
  modport slave  (input req, a_flat, b_flat, res_ready, output gnt, busy, res_valid, res_data, res_id);
`endif
endinterface

// File: rtl/xor_arb_ctrl.sv
// xor_arb_ctrl: round-robin arbiter sharing one registered XOR stage among NREQ clients
// Optional even-parity output on the result is enabled by defining XOR_ARB_PARITY_EN.
module xor_arb_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic clk,
  input  logic rst_n,
  xor_arb_ctrl_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, res_id_q, res_id_d, win;
  logic [IDW:0]     pos;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d, busy_q, busy_d;
`ifdef XOR_ARB_PARITY_EN
  logic             res_parity_q, res_parity_d;
  assign bus.res_parity = res_parity_q;
`endif
  // Scan offsets high to low so the requester nearest ptr is the final assignment.
  always_comb begin
    win = '0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (IDW + 1)'(k);
      pos = (pos >= (IDW + 1)'(NREQ)) ? pos - (IDW + 1)'(NREQ) : pos;
      if (bus.req[pos[IDW-1:0]]) win = pos[IDW-1:0];
    end
  end
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    a_d         = a_q;
    b_d         = b_q;
`ifdef XOR_ARB_PARITY_EN
    res_parity_d = res_parity_q;
`endif
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d  = EXEC;
        a_d      = bus.a_flat[win*WIDTH +: WIDTH];
        b_d      = bus.b_flat[win*WIDTH +: WIDTH];
        gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << win;
        res_id_d = win;
        ptr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
      EXEC: begin
        state_d     = RESP;
        res_data_d  = a_q ^ b_q;
        res_valid_d = 1'b1;
`ifdef XOR_ARB_PARITY_EN
        res_parity_d = ^(a_q ^ b_q);
`endif
      end
      RESP: if (bus.res_ready) begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
`ifdef XOR_ARB_PARITY_EN
      res_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifdef XOR_ARB_PARITY_EN
      res_parity_q <= res_parity_d;
`endif
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_xor_arb_ctrl.sv
// tb_xor_arb_ctrl: directed self-checking bench for xor_arb_ctrl (WIDTH=8, NREQ=4)
module tb_xor_arb_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  xor_arb_ctrl_if #(.WIDTH(8), .NREQ(4)) bus ();
  xor_arb_ctrl #(.WIDTH(8), .NREQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111;
    bus.res_ready = 1'b1;
    bus.a_flat = '0;
    bus.b_flat = '0;
    tick();
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.res_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.res_data); end
    checks++; if (bus.res_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.res_id); end
`ifdef XOR_ARB_PARITY_EN
    checks++; if (bus.res_parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", bus.res_parity); end
`endif
    rst_n = 1'b1;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want 1", bus.busy); end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.a_flat = 32'h00A5_0000;
    bus.b_flat = 32'h003C_0000;
    bus.req = 4'b0100;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", bus.res_valid); end
    bus.req = '0;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); end
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.res_valid); end
    checks++; if (bus.res_data !== 8'h99) begin errors++; $display("FAIL single_data: got %h want 99", bus.res_data); end
    checks++; if (bus.res_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", bus.res_id); end
`ifdef XOR_ARB_PARITY_EN
    checks++; if (bus.res_parity !== 1'b0) begin errors++; $display("FAIL single_parity: got %b want 0", bus.res_parity); end
`endif
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_valid_fall: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_res [4] = '{8'h1E, 8'h2D, 8'h3C, 8'h4B};
    do_reset();
    bus.a_flat = 32'h4433_2211;
    bus.b_flat = 32'h0F0F_0F0F;
    bus.req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      int g, ph;
      logic [3:0] exp_gnt;
      tick();
      g = ((c - 1) / 3) % 4;
      ph = (c - 1) % 3;
      exp_gnt = (ph == 0) ? 4'(1 << g) : 4'b0000;
      checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b want %b", c, bus.gnt, exp_gnt); end
      checks++; if (bus.res_valid !== (ph == 1)) begin errors++; $display("FAIL rr_valid cycle %0d: got %b want %b", c, bus.res_valid, ph == 1); end
      if (ph == 1) begin
        checks++; if (bus.res_data !== exp_res[g]) begin errors++; $display("FAIL rr_data cycle %0d: got %h want %h", c, bus.res_data, exp_res[g]); end
        checks++; if (bus.res_id !== 2'(g)) begin errors++; $display("FAIL rr_id cycle %0d: got %0d want %0d", c, bus.res_id, g); end
      end
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.a_flat = 32'h0000_5500;
    bus.b_flat = 32'h0000_AA00;
    bus.res_ready = 1'b0;
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL bp_gnt: got %b want 0010", bus.gnt); end
    bus.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid hold %0d: got %b want 1", i, bus.res_valid); end
      checks++; if (bus.res_data !== 8'hFF) begin errors++; $display("FAIL bp_data hold %0d: got %h want ff", i, bus.res_data); end
      checks++; if (bus.res_id !== 2'd1) begin errors++; $display("FAIL bp_id hold %0d: got %0d want 1", i, bus.res_id); end
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt hold %0d: got %b want 0000", i, bus.gnt); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_busy hold %0d: got %b want 1", i, bus.busy); end
    end
    bus.req = '0;
    bus.res_ready = 1'b1;
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b want 0", bus.busy); end
    bus.req = 4'b1111;
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL bp_next_gnt: got %b want 0100", bus.gnt); end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_operand_hold();
    do_reset();
    bus.a_flat = 32'h0000_FF00;
    bus.b_flat = 32'h0000_0F00;
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL hold_gnt: got %b want 0010", bus.gnt); end
    bus.a_flat = 32'h0000_0000;
    bus.req = '0;
    tick();
    checks++; if (bus.res_data !== 8'hF0) begin errors++; $display("FAIL hold_data: got %h want f0", bus.res_data); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus.a_flat = 32'h1234_5678;
    bus.b_flat = 32'h0000_0000;
    bus.res_ready = 1'b0;
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %b want 1", bus.res_valid); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    bus.req = 4'b1010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_ptr_zero_gnt: got %b want 0010", bus.gnt); end
    bus.req = '0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL mid_gnt3: got %b want 1000", bus.gnt); end
    bus.req = '0;
    tick();
    tick();
    bus.req = 4'b1111;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b want 0001", bus.gnt); end
    bus.req = '0;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    bus.res_ready = 1'b1;
    bus.a_flat = '0;
    bus.b_flat = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_operand_hold();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
